// File: rtl/mci_mcu_trace_drain.sv
// Bus-initiator that walks the MCU trace buffer CSRs and streams the stored
// trace as 4-dword packets, oldest first, over a valid/ready port.
module mci_mcu_trace_drain #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 8'h00,
    parameter logic [ADDR_WIDTH-1:0] CONFIG_ADDR = 8'h04,
    parameter logic [ADDR_WIDTH-1:0] DATA_ADDR   = 8'h08,
    parameter logic [ADDR_WIDTH-1:0] WR_PTR_ADDR = 8'h0C,
    parameter logic [ADDR_WIDTH-1:0] RD_PTR_ADDR = 8'h10
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [127:0]          pkt_data,
    output logic [15:0]           pkt_index,
    output logic                  req_dv,
    output logic                  req_write,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [31:0]           req_wdata,
    output logic [3:0]            req_wstrb,
    input  logic                  resp_hold,
    input  logic [31:0]           resp_rdata,
    input  logic                  resp_error
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_STATUS = 3'd1,
        ST_RD_CONFIG = 3'd2,
        ST_RD_WRPTR  = 3'd3,
        ST_WR_RDPTR  = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_EMIT      = 3'd6,
        ST_DONE      = 3'd7
    } state_e;

    state_e                state_q, state_d;
    logic                  wrapped_q, wrapped_d;
    logic [29:0]           depth_q, depth_d;
    logic [29:0]           cur_pkt_q, cur_pkt_d;
    logic [29:0]           remaining_q, remaining_d;
    logic [1:0]            off_q, off_d;
    logic                  abort_pend_q, abort_pend_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                  pkt_valid_q, pkt_valid_d;
    logic [127:0]          pkt_data_q, pkt_data_d;
    logic [15:0]           pkt_index_q, pkt_index_d;
    logic                  req_dv_q, req_dv_d, req_write_q, req_write_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [31:0]           req_wdata_q, req_wdata_d;
    logic [3:0]            req_wstrb_q, req_wstrb_d;

    logic        access_st_s, acc_done_s, emit_hs_s;
    logic [29:0] rem_init_s, start_init_s, cur_pkt_inc_s;

    assign access_st_s   = (state_q == ST_RD_STATUS) || (state_q == ST_RD_CONFIG) ||
                           (state_q == ST_RD_WRPTR)  || (state_q == ST_WR_RDPTR)  ||
                           (state_q == ST_RD_DATA);
    assign acc_done_s    = req_dv_q & ~resp_hold;
    assign emit_hs_s     = (state_q == ST_EMIT) & ~abort & pkt_ready;
    assign rem_init_s    = wrapped_q ? depth_q : resp_rdata[31:2];
    assign start_init_s  = wrapped_q ? resp_rdata[31:2] : 30'd0;
    assign cur_pkt_inc_s = cur_pkt_q + 30'd1;

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= ST_IDLE;
            wrapped_q    <= 1'b0;
            depth_q      <= 30'd0;
            cur_pkt_q    <= 30'd0;
            remaining_q  <= 30'd0;
            off_q        <= 2'd0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            pkt_valid_q  <= 1'b0;
            pkt_data_q   <= 128'd0;
            pkt_index_q  <= 16'd0;
            req_dv_q     <= 1'b0;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= 32'd0;
            req_wstrb_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            wrapped_q    <= wrapped_d;
            depth_q      <= depth_d;
            cur_pkt_q    <= cur_pkt_d;
            remaining_q  <= remaining_d;
            off_q        <= off_d;
            abort_pend_q <= abort_pend_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            pkt_valid_q  <= pkt_valid_d;
            pkt_data_q   <= pkt_data_d;
            pkt_index_q  <= pkt_index_d;
            req_dv_q     <= req_dv_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_wstrb_q  <= req_wstrb_d;
        end
    end

    // Next-state logic; an access state idles one cycle with req_dv low before issuing
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (abort)      state_d = ST_IDLE;
                else if (start) state_d = ST_RD_STATUS;
                else            state_d = ST_IDLE;
            end
            ST_RD_STATUS, ST_RD_CONFIG, ST_RD_WRPTR, ST_WR_RDPTR, ST_RD_DATA: begin
                if (!req_dv_q) begin
                    if (abort) state_d = ST_IDLE;
                    else       state_d = state_q;
                end else if (acc_done_s) begin
                    if (resp_error || abort || abort_pend_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        case (state_q)
                            ST_RD_STATUS: state_d = resp_rdata[0] ? ST_RD_CONFIG : ST_DONE;
                            ST_RD_CONFIG: state_d = ST_RD_WRPTR;
                            ST_RD_WRPTR:  state_d = (rem_init_s == 30'd0) ? ST_DONE : ST_WR_RDPTR;
                            ST_WR_RDPTR:  state_d = ST_RD_DATA;
                            ST_RD_DATA:   state_d = (off_q == 2'd3) ? ST_EMIT : ST_WR_RDPTR;
                            default:      state_d = ST_IDLE;
                        endcase
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_EMIT: begin
                if (abort)          state_d = ST_IDLE;
                else if (pkt_ready) state_d = (remaining_q == 30'd1) ? ST_DONE : ST_WR_RDPTR;
                else                state_d = ST_EMIT;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        wrapped_d    = wrapped_q;
        depth_d      = depth_q;
        cur_pkt_d    = cur_pkt_q;
        remaining_d  = remaining_q;
        off_d        = off_q;
        err_d        = err_q;
        pkt_data_d   = pkt_data_q;
        pkt_index_d  = pkt_index_q;
        req_dv_d     = req_dv_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_wstrb_d  = req_wstrb_q;
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        pkt_valid_d  = (state_d == ST_EMIT);

        if (state_d == ST_IDLE)               abort_pend_d = 1'b0;
        else if (abort && req_dv_q)           abort_pend_d = 1'b1;
        else                                  abort_pend_d = abort_pend_q;

        if (state_q == ST_IDLE && state_d == ST_RD_STATUS) begin
            err_d       = 1'b0;
            wrapped_d   = 1'b0;
            depth_d     = 30'd0;
            cur_pkt_d   = 30'd0;
            remaining_d = 30'd0;
            off_d       = 2'd0;
            pkt_index_d = 16'd0;
        end else if (access_st_s && !req_dv_q && state_d == state_q) begin
            req_dv_d    = 1'b1;
            req_write_d = (state_q == ST_WR_RDPTR);
            req_wdata_d = (state_q == ST_WR_RDPTR) ? {cur_pkt_q, off_q} : 32'd0;
            req_wstrb_d = (state_q == ST_WR_RDPTR) ? 4'hF : 4'h0;
            case (state_q)
                ST_RD_STATUS: req_addr_d = STATUS_ADDR;
                ST_RD_CONFIG: req_addr_d = CONFIG_ADDR;
                ST_RD_WRPTR:  req_addr_d = WR_PTR_ADDR;
                ST_WR_RDPTR:  req_addr_d = RD_PTR_ADDR;
                ST_RD_DATA:   req_addr_d = DATA_ADDR;
                default:      req_addr_d = req_addr_q;
            endcase
        end else if (access_st_s && acc_done_s) begin
            req_dv_d = 1'b0;
            if (resp_error) begin
                err_d = 1'b1;
            end else begin
                case (state_q)
                    ST_RD_STATUS: wrapped_d = resp_rdata[1];
                    ST_RD_CONFIG: depth_d = resp_rdata[31:2];
                    ST_RD_WRPTR: begin
                        cur_pkt_d   = start_init_s;
                        remaining_d = rem_init_s;
                    end
                    ST_RD_DATA: begin
                        pkt_data_d[{off_q, 5'b00000} +: 32] = resp_rdata;
                        off_d = (off_q == 2'd3) ? off_q : off_q + 2'd1;
                    end
                    default: off_d = off_q;
                endcase
            end
        end else if (emit_hs_s) begin
            off_d       = 2'd0;
            pkt_index_d = pkt_index_q + 16'd1;
            remaining_d = remaining_q - 30'd1;
            cur_pkt_d   = (cur_pkt_inc_s == depth_q) ? 30'd0 : cur_pkt_inc_s;
        end else begin
            req_dv_d = req_dv_q;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign pkt_valid = pkt_valid_q;
    assign pkt_data  = pkt_data_q;
    assign pkt_index = pkt_index_q;
    assign req_dv    = req_dv_q;
    assign req_write = req_write_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;
    assign req_wstrb = req_wstrb_q;
endmodule
